obi_rr_port_arbiter: RTL and testbench
======================================

// Module: obi_rr_port_arbiter
// PURPOSE
//  Shares one OBI-style memory port (e.g. imem/L2 bank) between N requesters:
//  core instr fetch, core data and debug-module system bus access (JTAG load).
//  Round-robin grant; one outstanding transaction. Response is routed back to its owner.
//  Response timeout returns an error instead of hanging the bus.
// PARAMETERS
//  N_REQ      3      number of requesters (2..8)
//  AW         32     address width
//  DW         32     data width (BE width = DW/8)
//  TIMEOUT    255    cycles to wait for mem_rvalid after grant; 0 = no timeout
// PORTS
//  clk_in      in   1          system clock
//  reset       in   1          synchronous reset, active-high
//  req_i       in   N_REQ      per-requester request
//  addr_i      in   N_REQ*AW   per-requester address, requester k at [k*AW +: AW]
//  we_i        in   N_REQ      per-requester write enable
//  be_i        in   N_REQ*DW/8 per-requester byte enables
//  wdata_i     in   N_REQ*DW   per-requester write data
//  gnt_o       out  N_REQ      one-hot grant
//  rvalid_o    out  N_REQ      one-hot response valid
//  rdata_o     out  DW         response data, shared, qualified by rvalid_o
//  err_o       out  1          response error (timeout), qualified by rvalid_o
//  mem_req_o   out  1          memory request
//  mem_addr_o  out  AW         memory address
//  mem_we_o    out  1          memory write enable
//  mem_be_o    out  DW/8       memory byte enables
//  mem_wdata_o out  DW         memory write data
//  mem_gnt_i   in   1          memory grant
//  mem_rvalid_i in  1          memory response valid
//  mem_rdata_i in   DW         memory read data
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, owner=0, tmo_cnt=0. All outputs 0 (gnt/rvalid/mem_req/err/rdata).
//  Arbitration:
//   - Winner = first asserted req_i scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
//  IDLE:
//   - No req: mem_req_o=0, stay.
//   - Any req: mem_req_o=1 same cycle, mem_* fields muxed from the winner.
//   - mem_gnt_i=1: gnt_o[winner]=1 same cycle (0-cycle grant latency), owner<=winner,
//     ptr<=(winner+1)%N_REQ, go WAIT.
//   - mem_gnt_i=0: sel<=winner, go HOLD.
//  HOLD:
//   - mem_req_o=1 with fields from locked sel; arbitration frozen (OBI stability rule).
//   - Newly arriving higher-priority reqs are ignored.
//   - mem_gnt_i=1: gnt_o[sel]=1, owner<=sel, ptr<=(sel+1)%N_REQ, go WAIT.
//   - Requesters must hold req/fields until gnt; retraction is a protocol violation and is not handled.
//  WAIT:
//   - mem_req_o=0; gnt_o=0; tmo_cnt increments each cycle from 0.
//   - mem_rvalid_i=1: rvalid_o[owner]=1, rdata_o=mem_rdata_i, err_o=0 same cycle
//     (combinational pass-through), go IDLE.
//   - TIMEOUT!=0 and tmo_cnt==TIMEOUT-1 with no rvalid: rvalid_o[owner]=1, err_o=1,
//     rdata_o=32'hBADCAB1E (DW>32: zero-extended), go IDLE.
//   - rvalid and timeout in the same cycle: the real response wins, err_o=0.
//  Throughput: no new request is accepted in the cycle rvalid_o fires; max 1 transaction per 2 cycles.
//  Stray mem_rvalid_i in IDLE/HOLD (late after timeout) is dropped; rvalid_o stays 0.
//  rdata_o and err_o are 0 whenever rvalid_o==0.
//  Reset mid-transaction: returns to IDLE next cycle; any pending response is dropped, ptr=0.
//  gnt_o and rvalid_o are always one-hot or zero.
// TESTING
//  1 Single req: req_i=3'b010, addr=0x0100_0080, mem_gnt=1 -> gnt_o=010 same cycle;
//    mem_rvalid 2 cycles later with 0xDEADBEEF -> rvalid_o=010, rdata_o=0xDEADBEEF, err_o=0.
//  2 Fairness: req_i=3'b111 held, gnt every grant cycle, rvalid 1 cycle after -> grant order 0,1,2,0,1,2.
//  3 Stall: req_i=001, mem_gnt=0 for 4 cycles while req 2 asserts -> mem_addr_o stable at req0's address;
//    gnt_o=001 when mem_gnt rises; req2 granted in the next IDLE.
//  4 Timeout: TIMEOUT=8, grant req1, no rvalid -> 8 cycles after grant: rvalid_o=010, err_o=1,
//    rdata_o=0xBADCAB1E; late mem_rvalid afterwards -> no rvalid_o.
//  5 Write pass-through: req2 we=1, be=4'b0011, wdata=0x1234_5678 -> identical mem_we/be/wdata;
//    ack routed to rvalid_o[2].
//  6 Reset in WAIT: assert reset 1 cycle after grant -> all outputs 0 next cycle;
//    a following req_i=100 is granted with ptr=0 priority.

Source files
------------

// File: rtl/obi_rr_port_arbiter_if.sv
// Bus bundle for the round-robin OBI port arbiter: requester-side request
// fields, per-requester grant/response strobes and the shared memory port.
interface obi_rr_port_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  // requester side
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*AW-1:0]     addr_i;
  logic [N_REQ-1:0]        we_i;
  logic [N_REQ*DW/8-1:0]   be_i;
  logic [N_REQ*DW-1:0]     wdata_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        rvalid_o;
  logic [DW-1:0]           rdata_o;
  logic                    err_o;
  // memory side
  logic                    mem_req_o;
  logic [AW-1:0]           mem_addr_o;
  logic                    mem_we_o;
  logic [DW/8-1:0]         mem_be_o;
  logic [DW-1:0]           mem_wdata_o;
  logic                    mem_gnt_i;
  logic                    mem_rvalid_i;
  logic [DW-1:0]           mem_rdata_i;

  // arbiter view
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  // environment view (requesters + memory)
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/obi_rr_port_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between N_REQ requesters.
// One outstanding transaction; the response is routed back to the granted
// requester, and a missing response is converted into an error after TIMEOUT
// cycles so the bus never hangs.
module obi_rr_port_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk_in,
  input  logic                  reset,
  obi_rr_port_arbiter_if.slave  bus
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BW = DW / 8;

  localparam logic [DW-1:0] TMO_DATA = DW'(32'hBADCAB1E);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] owner;
  logic [TW-1:0] tmo_cnt;

  logic [AW-1:0] addr_a  [N_REQ];
  logic [BW-1:0] be_a    [N_REQ];
  logic [DW-1:0] wdata_a [N_REQ];

  logic          any_req;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  int unsigned   idx;

  logic          active;
  logic [PW-1:0] src;
  logic          in_wait;
  logic          tmo_hit;
  logic          rsp_fire;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] k);
    if (32'(k) == N_REQ - 1)
      return '0;
    return k + 1'b1;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.addr_i[g*AW +: AW];
    assign be_a[g]    = bus.be_i[g*BW +: BW];
    assign wdata_a[g] = bus.wdata_i[g*DW +: DW];
  end

  // Rotating-priority scan: first asserted request starting at ptr.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    idx     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N_REQ)
        idx = idx - N_REQ;
      cand = PW'(idx);
      if (!any_req && bus.req_i[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  // Request path: live winner in IDLE, locked selection in HOLD.
  always_comb begin
    active = !reset && (((state == S_IDLE) && any_req) || (state == S_HOLD));
    src    = (state == S_HOLD) ? sel : win;

    bus.mem_req_o   = active;
    bus.mem_addr_o  = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_wdata_o = '0;
    bus.gnt_o       = '0;
    if (active) begin
      bus.mem_addr_o  = addr_a[src];
      bus.mem_we_o    = bus.we_i[src];
      bus.mem_be_o    = be_a[src];
      bus.mem_wdata_o = wdata_a[src];
      bus.gnt_o[src]  = bus.mem_gnt_i;
    end
  end

  // Response path: pass-through of the memory response, or a synthesized
  // error when the wait budget runs out (a real response takes precedence).
  always_comb begin
    in_wait  = !reset && (state == S_WAIT);
    tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));
    rsp_fire = in_wait && (bus.mem_rvalid_i || tmo_hit);

    bus.rvalid_o = '0;
    bus.rdata_o  = '0;
    bus.err_o    = 1'b0;
    if (rsp_fire) begin
      bus.rvalid_o[owner] = 1'b1;
      if (bus.mem_rvalid_i) begin
        bus.rdata_o = bus.mem_rdata_i;
      end else begin
        bus.rdata_o = TMO_DATA;
        bus.err_o   = 1'b1;
      end
    end
  end

  // Transaction sequencing, pointer rotation and timeout counting.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      sel     <= '0;
      owner   <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            if (bus.mem_gnt_i) begin
              owner   <= win;
              ptr     <= next_ptr(win);
              tmo_cnt <= '0;
              state   <= S_WAIT;
            end else begin
              sel   <= win;
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.mem_gnt_i) begin
            owner   <= sel;
            ptr     <= next_ptr(sel);
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_fire) begin
            tmo_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obi_rr_port_arbiter.sv
// Directed bench for obi_rr_port_arbiter with a scoreboard: the stimulus
// pushes expected grant/response events, a negedge monitor pops and compares
// whenever the DUT raises gnt_o or rvalid_o.
module tb_obi_rr_port_arbiter;

  localparam int unsigned N_REQ = 3;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  typedef struct {
    bit          is_rsp;
    logic [2:0]  vec;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sbq[$];

  obi_rr_port_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

  obi_rr_port_arbiter #(
    .N_REQ(N_REQ), .AW(AW), .DW(DW), .TIMEOUT(8)
  ) dut (
    .clk_in(clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected done by 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_gnt(input logic [2:0] v);
    exp_t e;
    e.is_rsp = 1'b0; e.vec = v; e.data = '0; e.err = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic exp_rsp(input logic [2:0] v, input logic [31:0] d, input logic er);
    exp_t e;
    e.is_rsp = 1'b1; e.vec = v; e.data = d; e.err = er;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // Monitor: every grant/response the DUT presents must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (|bus.gnt_o) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_gnt: got %b expected none", bus.gnt_o);
      end else begin
        e = sbq.pop_front();
        if (e.is_rsp || bus.gnt_o !== e.vec) begin
          bad++;
          $display("FAIL gnt: got gnt=%b expected %s %b", bus.gnt_o,
                   e.is_rsp ? "rsp" : "gnt", e.vec);
        end
      end
    end
    if (|bus.rvalid_o) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rvalid: got %b data=%h expected none", bus.rvalid_o, bus.rdata_o);
      end else begin
        e = sbq.pop_front();
        if (!e.is_rsp || bus.rvalid_o !== e.vec || bus.rdata_o !== e.data || bus.err_o !== e.err) begin
          bad++;
          $display("FAIL rsp: got rvalid=%b data=%h err=%b expected %s vec=%b data=%h err=%b",
                   bus.rvalid_o, bus.rdata_o, bus.err_o, e.is_rsp ? "rsp" : "gnt",
                   e.vec, e.data, e.err);
        end
      end
    end
    total++;
    if (!$onehot0(bus.gnt_o) || !$onehot0(bus.rvalid_o) ||
        (bus.rvalid_o == '0 && (bus.rdata_o !== '0 || bus.err_o !== 1'b0))) begin
      bad++;
      $display("FAIL invariant: got gnt=%b rvalid=%b rdata=%h err=%b expected onehot0 and idle-zero",
               bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.err_o);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req_i        = '0;
    bus.addr_i       = '0;
    bus.we_i         = '0;
    bus.be_i         = '0;
    bus.wdata_i      = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus.gnt_o, bus.rvalid_o, bus.mem_req_o, bus.err_o, bus.rdata_o}, '0);
    cyc();
    reset = 1'b0;

    // single request from requester 1
    bus.addr_i[1*AW +: AW] = 32'h0100_0080;
    bus.req_i     = 3'b010;
    bus.mem_gnt_i = 1'b1;
    exp_gnt(3'b010);
    @(negedge clk);
    check("t1_mem_req", bus.mem_req_o, 1'b1);
    check("t1_mem_addr", bus.mem_addr_o, 32'h0100_0080);
    cyc();
    bus.req_i     = '0;
    bus.mem_gnt_i = 1'b0;
    cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEAD_BEEF;
    exp_rsp(3'b010, 32'hDEAD_BEEF, 1'b0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    // fairness with all three requesting
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      bus.req_i     = 3'b111;
      bus.mem_gnt_i = 1'b1;
      exp_gnt(3'b001 << (i % 3));
      cyc();
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'h0000_00A0 + 32'(i);
      exp_rsp(3'b001 << (i % 3), 32'h0000_00A0 + 32'(i), 1'b0);
      cyc();
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
    end
    bus.req_i = '0;

    // stall: fields locked while a competing request arrives
    bus.addr_i[0*AW +: AW] = 32'h0000_4000;
    bus.addr_i[2*AW +: AW] = 32'h2000_0000;
    bus.req_i     = 3'b001;
    bus.mem_gnt_i = 1'b0;
    @(negedge clk);
    check("t3_addr_c0", bus.mem_addr_o, 32'h0000_4000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.req_i = 3'b101;
      @(negedge clk);
      check("t3_hold_addr", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h0000_4000});
    end
    cyc();
    bus.mem_gnt_i = 1'b1;
    exp_gnt(3'b001);
    cyc();
    bus.mem_gnt_i    = 1'b0;
    bus.req_i        = 3'b100;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0000_0055;
    exp_rsp(3'b001, 32'h0000_0055, 1'b0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_gnt_i    = 1'b1;
    exp_gnt(3'b100);
    @(negedge clk);
    check("t3_req2_addr", bus.mem_addr_o, 32'h2000_0000);
    cyc();
    bus.mem_gnt_i    = 1'b0;
    bus.req_i        = '0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0000_0066;
    exp_rsp(3'b100, 32'h0000_0066, 1'b0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    // timeout on requester 1, then a stray late response
    bus.addr_i[1*AW +: AW] = 32'h0100_0100;
    bus.req_i     = 3'b010;
    bus.mem_gnt_i = 1'b1;
    exp_gnt(3'b010);
    cyc();
    bus.req_i     = '0;
    bus.mem_gnt_i = 1'b0;
    repeat (6) cyc();
    cyc();
    exp_rsp(3'b010, 32'hBADC_AB1E, 1'b1);
    cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0000_0077;
    @(negedge clk);
    check("t4_stray_rvalid", bus.rvalid_o, 3'b000);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    // write pass-through from requester 2
    bus.addr_i[2*AW +: AW]  = 32'h3000_0010;
    bus.we_i                = 3'b100;
    bus.be_i[2*4 +: 4]      = 4'b0011;
    bus.wdata_i[2*DW +: DW] = 32'h1234_5678;
    bus.req_i     = 3'b100;
    bus.mem_gnt_i = 1'b1;
    exp_gnt(3'b100);
    @(negedge clk);
    check("t5_write_fields",
          {bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o, bus.mem_addr_o},
          {1'b1, 4'b0011, 32'h1234_5678, 32'h3000_0010});
    cyc();
    bus.req_i        = '0;
    bus.we_i         = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = '0;
    exp_rsp(3'b100, 32'h0, 1'b0);
    cyc();
    bus.mem_rvalid_i = 1'b0;

    // reset while waiting for a response
    bus.req_i     = 3'b010;
    bus.mem_gnt_i = 1'b1;
    exp_gnt(3'b010);
    cyc();
    bus.req_i     = '0;
    bus.mem_gnt_i = 1'b0;
    reset         = 1'b1;
    cyc();
    reset            = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0000_0099;
    @(negedge clk);
    check("t6_after_reset",
          {bus.gnt_o, bus.rvalid_o, bus.mem_req_o, bus.err_o, bus.rdata_o}, '0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.req_i        = 3'b110;
    bus.mem_gnt_i    = 1'b1;
    exp_gnt(3'b010);
    cyc();
    bus.req_i        = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0000_0011;
    exp_rsp(3'b010, 32'h0000_0011, 1'b0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    repeat (2) cyc();
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
